// File: rtl/cordic_host_client.sv
// Host-side initiator for the CORDIC engine: packs a command into request words,
// drains and tag-checks the response words, and presents one registered result beat.
module cordic_host_client #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_mode,
    input  logic [31:0] cmd_x,
    input  logic [31:0] cmd_y,
    input  logic        req_full,
    output logic        req_wr_en,
    output logic [47:0] req_data,
    input  logic        rsp_empty,
    output logic        rsp_rd_en,
    input  logic [47:0] rsp_data,
    output logic        res_valid,
    output logic [31:0] res0,
    output logic [31:0] res1,
    output logic [31:0] res2,
    output logic [1:0]  res_err,
    output logic        busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_REQ1,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [7:0]    mode_reg, mode_next;
    logic [31:0]   y_reg, y_next;
    logic [1:0]    idx_reg, idx_next;
    logic [TW-1:0] tmo_reg, tmo_next;
    logic          mismatch_reg, mismatch_next;
    logic [31:0]   slot_reg [3];
    logic [31:0]   slot_next [3];

    logic          cmd_ready_reg, cmd_ready_next;
    logic          req_wr_en_reg, req_wr_en_next;
    logic [47:0]   req_data_reg, req_data_next;
    logic          rsp_rd_en_reg, rsp_rd_en_next;
    logic          res_valid_reg, res_valid_next;
    logic [31:0]   res_reg [3];
    logic [31:0]   res_next [3];
    logic [1:0]    res_err_reg, res_err_next;
    logic          busy_reg, busy_next;

    function automatic logic [1:0] words_for_mode(input logic [7:0] mode);
        case (mode)
            8'd1, 8'd2, 8'd4: words_for_mode = 2'd2;
            8'd3:             words_for_mode = 2'd3;
            default:          words_for_mode = 2'd1;
        endcase
    endfunction

    function automatic logic [15:0] expected_tag(input logic [7:0] mode, input logic [1:0] idx);
        case (mode)
            8'd1, 8'd2, 8'd4: expected_tag = (idx == 2'd0) ? 16'h000A : 16'h000C;
            8'd3: begin
                case (idx)
                    2'd0:    expected_tag = 16'h000A;
                    2'd1:    expected_tag = 16'h000C;
                    default: expected_tag = 16'h000B;
                endcase
            end
            8'd5:    expected_tag = 16'h000E;
            8'd6:    expected_tag = 16'h000F;
            8'd7:    expected_tag = 16'h000D;
            default: expected_tag = 16'h000B;
        endcase
    endfunction

    // Every output is registered, so the next-state logic decides what each
    // strobe will be in the cycle after the current edge.
    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        y_next         = y_reg;
        idx_next       = idx_reg;
        tmo_next       = tmo_reg;
        mismatch_next  = mismatch_reg;
        slot_next      = slot_reg;
        req_wr_en_next = 1'b0;
        req_data_next  = req_data_reg;
        rsp_rd_en_next = 1'b0;
        res_valid_next = 1'b0;
        res_next       = res_reg;
        res_err_next   = res_err_reg;

        case (state_reg)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_reg) begin
                    mode_next     = cmd_mode;
                    y_next        = cmd_y;
                    idx_next      = 2'd0;
                    tmo_next      = '0;
                    mismatch_next = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        slot_next[i] = '0;
                    end
                    if ((cmd_mode == 8'd0) || (cmd_mode > 8'd8)) begin
                        state_next     = S_DONE;
                        res_valid_next = 1'b1;
                        res_err_next   = 2'd1;
                        for (int i = 0; i < 3; i++) begin
                            res_next[i] = '0;
                        end
                    end else begin
                        state_next     = S_REQ0;
                        req_data_next  = {cmd_x, cmd_mode, 8'h00};
                        req_wr_en_next = !req_full;
                    end
                end
            end

            S_REQ0: begin
                if (req_wr_en_reg) begin
                    if (mode_reg == 8'd8) begin
                        state_next     = S_REQ1;
                        req_data_next  = {y_reg, mode_reg, 8'h00};
                        req_wr_en_next = !req_full;
                    end else begin
                        state_next     = S_WAIT;
                        rsp_rd_en_next = !rsp_empty;
                    end
                end else begin
                    req_wr_en_next = !req_full;
                end
            end

            S_REQ1: begin
                if (req_wr_en_reg) begin
                    state_next     = S_WAIT;
                    rsp_rd_en_next = !rsp_empty;
                end else begin
                    req_wr_en_next = !req_full;
                end
            end

            S_WAIT: begin
                if (rsp_rd_en_reg) begin
                    state_next = S_SAMPLE;
                end else if (!rsp_empty) begin
                    rsp_rd_en_next = 1'b1;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                    if (tmo_next == TMO_LIMIT) begin
                        state_next     = S_DONE;
                        res_valid_next = 1'b1;
                        res_err_next   = 2'd3;
                        res_next       = slot_reg;
                    end
                end
            end

            S_SAMPLE: begin
                // A wrong tag is remembered but the word is still stored and counted.
                slot_next[idx_reg] = rsp_data[31:0];
                if (rsp_data[47:32] != expected_tag(mode_reg, idx_reg)) begin
                    mismatch_next = 1'b1;
                end
                tmo_next = '0;
                idx_next = idx_reg + 2'd1;
                if (idx_next == words_for_mode(mode_reg)) begin
                    state_next     = S_DONE;
                    res_valid_next = 1'b1;
                    res_next       = slot_next;
                    res_err_next   = mismatch_next ? 2'd2 : 2'd0;
                end else begin
                    state_next     = S_WAIT;
                    rsp_rd_en_next = !rsp_empty;
                end
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        cmd_ready_next = (state_next == S_IDLE);
        busy_next      = (state_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            mode_reg      <= '0;
            y_reg         <= '0;
            idx_reg       <= '0;
            tmo_reg       <= '0;
            mismatch_reg  <= 1'b0;
            cmd_ready_reg <= 1'b0;
            req_wr_en_reg <= 1'b0;
            req_data_reg  <= '0;
            rsp_rd_en_reg <= 1'b0;
            res_valid_reg <= 1'b0;
            res_err_reg   <= '0;
            busy_reg      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                slot_reg[i] <= '0;
                res_reg[i]  <= '0;
            end
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            y_reg         <= y_next;
            idx_reg       <= idx_next;
            tmo_reg       <= tmo_next;
            mismatch_reg  <= mismatch_next;
            cmd_ready_reg <= cmd_ready_next;
            req_wr_en_reg <= req_wr_en_next;
            req_data_reg  <= req_data_next;
            rsp_rd_en_reg <= rsp_rd_en_next;
            res_valid_reg <= res_valid_next;
            res_err_reg   <= res_err_next;
            busy_reg      <= busy_next;
            for (int i = 0; i < 3; i++) begin
                slot_reg[i] <= slot_next[i];
                res_reg[i]  <= res_next[i];
            end
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign req_wr_en = req_wr_en_reg;
    assign req_data  = req_data_reg;
    assign rsp_rd_en = rsp_rd_en_reg;
    assign res_valid = res_valid_reg;
    assign res0      = res_reg[0];
    assign res1      = res_reg[1];
    assign res2      = res_reg[2];
    assign res_err   = res_err_reg;
    assign busy      = busy_reg;

endmodule
